// File: rtl/ahb_reg_pkg.sv
// Shared types and helpers for the AHB-Lite register slave.
// Holds the HTRANS/HSIZE encodings, HRESP constants, the slave FSM state type
// and the byte-lane mask helper used for sub-word writes.
package ahb_reg_pkg;

  typedef enum logic [1:0] {
    TransIdle   = 2'd0,
    TransBusy   = 2'd1,
    TransNonseq = 2'd2,
    TransSeq    = 2'd3
  } htrans_e;

  typedef enum logic [2:0] {
    SizeByte = 3'd0,
    SizeHalf = 3'd1,
    SizeWord = 3'd2
  } hsize_e;

  localparam logic HrespOkay  = 1'b0;
  localparam logic HrespError = 1'b1;

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StErr1,
    StErr2
  } state_e;

  // Byte lanes touched by a transfer of the given size at the given byte offset.
  function automatic logic [3:0] lane_mask(logic [2:0] size, logic [1:0] byte_off);
    logic [3:0] mask;
    case (size)
      SizeByte: mask = 4'b0001 << byte_off;
      SizeHalf: mask = 4'b0011 << byte_off;
      SizeWord: mask = 4'b1111;
      default:  mask = 4'b0000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/addr_decoder.sv
// Address decoder for a 2**(OffsetWidth+2)-byte register window at BaseAddr.
// Ports:
//   addr_i        - byte address
//   in_range_o    - address falls inside the window
//   word_offset_o - 32-bit word index within the window
//   byte_offset_o - byte index within the word
module addr_decoder #(
  parameter logic [31:0] BaseAddr    = 32'h0000_0000,
  parameter int unsigned OffsetWidth = 6
) (
  input  logic [31:0]            addr_i,
  output logic                   in_range_o,
  output logic [OffsetWidth-1:0] word_offset_o,
  output logic [1:0]             byte_offset_o
);

  logic [31:0] rel;

  always_comb begin
    // Addresses below BaseAddr wrap to large values and fall out of range.
    rel           = addr_i - BaseAddr;
    in_range_o    = (rel[31:OffsetWidth+2] == '0);
    word_offset_o = rel[OffsetWidth+1:2];
    byte_offset_o = rel[1:0];
  end

endmodule

// File: rtl/ahb_reg_slave.sv
// AHB-Lite slave register file: 2**OffsetWidth 32-bit registers with byte-lane
// writes and zero-wait reads. Illegal transfers (out of window, HSIZE > word,
// misaligned) never modify state.
// Optional feature macro AHB_REG_ERROR_RESP_EN: when defined, illegal transfers
// get the two-cycle AHB ERROR response; when undefined they complete OKAY with
// zero wait states and read data 0.
// Ports:
//   HCLK, HRESETn            - clock, synchronous active-low reset
//   HSEL, HADDR, HTRANS,
//   HWRITE, HSIZE, HREADY    - address phase inputs
//   HWDATA                   - write data (data phase)
//   HRDATA, HREADYOUT, HRESP - data phase response
module ahb_reg_slave
  import ahb_reg_pkg::*;
#(
  parameter logic [31:0] BaseAddr    = 32'h0000_0000,
  parameter int unsigned OffsetWidth = 6
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP
);

  localparam int unsigned NumRegs = 2 ** OffsetWidth;

  logic                   dec_in_range;
  logic [OffsetWidth-1:0] dec_word_off;
  logic [1:0]             dec_byte_off;

  addr_decoder #(
    .BaseAddr   (BaseAddr),
    .OffsetWidth(OffsetWidth)
  ) u_addr_decoder (
    .addr_i       (HADDR),
    .in_range_o   (dec_in_range),
    .word_offset_o(dec_word_off),
    .byte_offset_o(dec_byte_off)
  );

  state_e                 state_q, state_d;
  logic                   valid_q, valid_d;
  logic                   write_q, write_d;
  logic [OffsetWidth-1:0] word_off_q, word_off_d;
  logic [1:0]             byte_off_q, byte_off_d;
  logic [2:0]             size_q, size_d;
  logic                   legal_q, legal_d;
  logic [31:0]            regs_q [NumRegs];
  logic [31:0]            regs_d [NumRegs];

  logic       accept;
  logic       aligned;
  logic       legal;
  logic       commit;
  logic [3:0] mask;

  // Address phase decode.
  always_comb begin
    accept = HSEL && HREADY && (HTRANS == TransNonseq || HTRANS == TransSeq);
    case (HSIZE)
      SizeHalf: aligned = ~dec_byte_off[0];
      SizeWord: aligned = (dec_byte_off == 2'b00);
      default:  aligned = 1'b1;
    endcase
    legal = dec_in_range && (HSIZE <= 3'd2) && aligned;
  end

  // Address phase capture; transfer attributes are held until the next accept.
  always_comb begin
    valid_d    = accept;
    write_d    = write_q;
    word_off_d = word_off_q;
    byte_off_d = byte_off_q;
    size_d     = size_q;
    legal_d    = legal_q;
    if (accept) begin
      write_d    = HWRITE;
      word_off_d = dec_word_off;
      byte_off_d = dec_byte_off;
      size_d     = HSIZE;
      legal_d    = legal;
    end
  end

  // Next state.
  always_comb begin
    state_d = StIdle;
`ifdef AHB_REG_ERROR_RESP_EN
    if (state_q == StErr1) begin
      state_d = StErr2;
    end else if (accept) begin
      state_d = legal ? StData : StErr1;
    end
`else
    if (accept) begin
      state_d = StData;
    end
`endif
  end

  // Write commit at the edge closing the data phase. legal_q also gates the
  // write when illegal transfers are routed through StData.
  always_comb begin
    commit = (state_q == StData) && valid_q && write_q && legal_q;
    mask   = lane_mask(size_q, byte_off_q);
    regs_d = regs_q;
    if (commit) begin
      for (int i = 0; i < 4; i++) begin
        if (mask[i]) begin
          regs_d[word_off_q][8*i +: 8] = HWDATA[8*i +: 8];
        end
      end
    end
  end

  // Response outputs.
  always_comb begin
    HREADYOUT = (state_q != StErr1);
    HRESP     = (state_q == StErr1 || state_q == StErr2) ? HrespError : HrespOkay;
    HRDATA    = '0;
    if (state_q == StData && !write_q && legal_q) begin
      HRDATA = regs_q[word_off_q];
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q    <= StIdle;
      valid_q    <= 1'b0;
      write_q    <= 1'b0;
      word_off_q <= '0;
      byte_off_q <= '0;
      size_q     <= '0;
      legal_q    <= 1'b0;
      regs_q     <= '{default: '0};
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      write_q    <= write_d;
      word_off_q <= word_off_d;
      byte_off_q <= byte_off_d;
      size_q     <= size_d;
      legal_q    <= legal_d;
      regs_q     <= regs_d;
    end
  end

endmodule

// File: tb/tb_ahb_reg_slave.sv
// Self-checking bench for ahb_reg_slave: directed scenarios plus randomized
// transfers compared against a behavioural register-file model.
module tb_ahb_reg_slave;

  localparam logic [31:0] Base     = 32'h4000_1000;
  localparam int          Ow       = 6;
  localparam int          NRegs    = 1 << Ow;
  localparam int          WinBytes = 4 << Ow;
`ifdef AHB_REG_ERROR_RESP_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic        hready;
  logic [31:0] hrdata;
  logic        hreadyout;
  logic        hresp;

  assign hready = hreadyout;

  ahb_reg_slave #(
    .BaseAddr   (Base),
    .OffsetWidth(Ow)
  ) dut (
    .HCLK     (clk),
    .HRESETn  (rst_n),
    .HSEL     (hsel),
    .HADDR    (haddr),
    .HTRANS   (htrans),
    .HWRITE   (hwrite),
    .HSIZE    (hsize),
    .HWDATA   (hwdata),
    .HREADY   (hready),
    .HRDATA   (hrdata),
    .HREADYOUT(hreadyout),
    .HRESP    (hresp)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [31:0] model [NRegs];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  // ---------------- behavioural model ----------------
  function automatic bit m_legal(logic [31:0] addr, logic [2:0] size);
    logic [31:0] off;
    off = addr - Base;
    if (off >= WinBytes) return 1'b0;
    if (size > 3'd2) return 1'b0;
    if (size == 3'd1 && off[0] != 1'b0) return 1'b0;
    if (size == 3'd2 && off[1:0] != 2'b00) return 1'b0;
    return 1'b1;
  endfunction

  // Predicts the two sampled cycles of an isolated transfer and updates the model.
  task automatic predict(input bit sel, input logic [1:0] trans, input bit wr,
                         input logic [31:0] addr, input logic [2:0] size,
                         input logic [31:0] wdata,
                         output logic e_rdy0, output logic e_resp0,
                         output logic [31:0] e_rd0, output logic e_rdy1,
                         output logic e_resp1);
    bit acc, lg;
    int idx, bo, nb;
    acc = sel && (trans >= 2'd2);
    lg  = m_legal(addr, size);
    idx = int'((addr - Base) >> 2) % NRegs;
    bo  = int'((addr - Base) & 32'd3);
    e_rdy0 = 1'b1; e_resp0 = 1'b0; e_rd0 = 32'h0; e_rdy1 = 1'b1; e_resp1 = 1'b0;
    if (acc) begin
      if (!lg && ErrEn) begin
        e_rdy0 = 1'b0; e_resp0 = 1'b1; e_resp1 = 1'b1;
      end else begin
        if (!wr && lg) e_rd0 = model[idx];
        if (wr && lg) begin
          nb = 1 << int'(size);
          for (int i = 0; i < 4; i++)
            if (i >= bo && i < bo + nb) model[idx][8*i +: 8] = wdata[8*i +: 8];
        end
      end
    end
  endtask

  // ---------------- bus driver ----------------
  task automatic idle_bus();
    hsel = 1'b0; htrans = 2'd0; hwrite = 1'b0; haddr = 32'h0; hsize = 3'd0; hwdata = 32'h0;
  endtask

  // One address phase followed by idle; samples the data phase and the cycle after.
  task automatic xfer(input bit sel, input logic [1:0] trans, input bit wr,
                      input logic [31:0] addr, input logic [2:0] size,
                      input logic [31:0] wdata,
                      output logic rdy0, output logic resp0, output logic [31:0] rd0,
                      output logic rdy1, output logic resp1);
    @(posedge clk); #1;
    hsel = sel; htrans = trans; hwrite = wr; haddr = addr; hsize = size;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'd0; hwdata = wdata;
    @(negedge clk);
    rdy0 = hreadyout; resp0 = hresp; rd0 = hrdata;
    @(posedge clk); #1;
    hwdata = 32'h0;
    @(negedge clk);
    rdy1 = hreadyout; resp1 = hresp;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic r0, p0, r1, p1;
    logic [31:0] d0;
    idle_bus();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < NRegs; i++) model[i] = 32'h0;
    @(negedge clk);
    checks++;
    if (hreadyout !== 1'b1) begin
      failures++; $display("FAIL reset_hreadyout: got %b expected 1", hreadyout);
    end
    checks++;
    if (hresp !== 1'b0) begin
      failures++; $display("FAIL reset_hresp: got %b expected 0", hresp);
    end
    checks++;
    if (hrdata !== 32'h0) begin
      failures++; $display("FAIL reset_hrdata: got %h expected 0", hrdata);
    end
    for (int i = 0; i < 4; i++) begin
      xfer(1'b1, 2'd2, 1'b0, Base + 32'(4 * i), 3'd2, 32'h0, r0, p0, d0, r1, p1);
      checks++;
      if (d0 !== 32'h0) begin
        failures++; $display("FAIL reset_reg%0d: got %h expected 0", i, d0);
      end
    end
  endtask

  task automatic test_word_rw();
    logic r0, p0, r1, p1, er0, ep0, er1, ep1;
    logic [31:0] d0, ed0;
    predict(1'b1, 2'd2, 1'b1, Base + 32'h4, 3'd2, 32'hDEAD_BEEF, er0, ep0, ed0, er1, ep1);
    xfer(1'b1, 2'd2, 1'b1, Base + 32'h4, 3'd2, 32'hDEAD_BEEF, r0, p0, d0, r1, p1);
    checks++;
    if (r0 !== 1'b1 || p0 !== 1'b0) begin
      failures++; $display("FAIL word_write_resp: got rdy=%b resp=%b expected rdy=1 resp=0", r0, p0);
    end
    predict(1'b1, 2'd2, 1'b0, Base + 32'h4, 3'd2, 32'h0, er0, ep0, ed0, er1, ep1);
    xfer(1'b1, 2'd2, 1'b0, Base + 32'h4, 3'd2, 32'h0, r0, p0, d0, r1, p1);
    checks++;
    if (d0 !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL word_readback: got %h expected deadbeef", d0);
    end
    checks++;
    if (r0 !== 1'b1 || p0 !== 1'b0) begin
      failures++; $display("FAIL word_read_resp: got rdy=%b resp=%b expected rdy=1 resp=0", r0, p0);
    end
  endtask

  task automatic test_byte_write();
    logic r0, p0, r1, p1, er0, ep0, er1, ep1;
    logic [31:0] d0, ed0;
    predict(1'b1, 2'd2, 1'b1, Base + 32'h4, 3'd2, 32'h1122_3344, er0, ep0, ed0, er1, ep1);
    xfer(1'b1, 2'd2, 1'b1, Base + 32'h4, 3'd2, 32'h1122_3344, r0, p0, d0, r1, p1);
    predict(1'b1, 2'd2, 1'b1, Base + 32'h6, 3'd0, 32'h55AA_5555, er0, ep0, ed0, er1, ep1);
    xfer(1'b1, 2'd2, 1'b1, Base + 32'h6, 3'd0, 32'h55AA_5555, r0, p0, d0, r1, p1);
    predict(1'b1, 2'd2, 1'b0, Base + 32'h4, 3'd2, 32'h0, er0, ep0, ed0, er1, ep1);
    xfer(1'b1, 2'd2, 1'b0, Base + 32'h4, 3'd2, 32'h0, r0, p0, d0, r1, p1);
    checks++;
    if (d0 !== 32'h11AA_3344) begin
      failures++; $display("FAIL byte_write: got %h expected 11aa3344", d0);
    end
  endtask

  task automatic test_back_to_back();
    logic er0, ep0, er1, ep1;
    logic [31:0] ed0;
    predict(1'b1, 2'd2, 1'b1, Base + 32'h10, 3'd2, 32'h5, er0, ep0, ed0, er1, ep1);
    @(posedge clk); #1;
    hsel = 1'b1; htrans = 2'd2; hwrite = 1'b1; haddr = Base + 32'h10; hsize = 3'd2;
    @(posedge clk); #1;
    hwrite = 1'b0; hwdata = 32'h5;
    @(posedge clk); #1;
    idle_bus();
    @(negedge clk);
    checks++;
    if (hrdata !== 32'h5 || hreadyout !== 1'b1 || hresp !== 1'b0) begin
      failures++;
      $display("FAIL back_to_back: got data=%h rdy=%b resp=%b expected data=5 rdy=1 resp=0",
               hrdata, hreadyout, hresp);
    end
  endtask

  task automatic test_error();
    logic r0, p0, r1, p1, er0, ep0, er1, ep1;
    logic [31:0] d0, ed0;
    predict(1'b1, 2'd2, 1'b0, Base + 32'(WinBytes), 3'd2, 32'h0, er0, ep0, ed0, er1, ep1);
    xfer(1'b1, 2'd2, 1'b0, Base + 32'(WinBytes), 3'd2, 32'h0, r0, p0, d0, r1, p1);
    checks++;
    if ({r0, p0, r1, p1} !== {ErrEn ? 1'b0 : 1'b1, ErrEn, 1'b1, ErrEn}) begin
      failures++;
      $display("FAIL out_of_range_resp: got rdy=%b%b resp=%b%b expected rdy=%b1 resp=%b%b",
               r0, r1, p0, p1, !ErrEn, ErrEn, ErrEn);
    end
    checks++;
    if (d0 !== 32'h0) begin
      failures++; $display("FAIL out_of_range_data: got %h expected 0", d0);
    end
    predict(1'b1, 2'd2, 1'b1, Base + 32'h2, 3'd2, 32'hFFFF_FFFF, er0, ep0, ed0, er1, ep1);
    xfer(1'b1, 2'd2, 1'b1, Base + 32'h2, 3'd2, 32'hFFFF_FFFF, r0, p0, d0, r1, p1);
    checks++;
    if (r0 !== er0 || p0 !== ep0 || p1 !== ep1) begin
      failures++;
      $display("FAIL misaligned_resp: got rdy=%b resp=%b%b expected rdy=%b resp=%b%b",
               r0, p0, p1, er0, ep0, ep1);
    end
    predict(1'b1, 2'd2, 1'b0, Base, 3'd2, 32'h0, er0, ep0, ed0, er1, ep1);
    xfer(1'b1, 2'd2, 1'b0, Base, 3'd2, 32'h0, r0, p0, d0, r1, p1);
    checks++;
    if (d0 !== ed0) begin
      failures++; $display("FAIL misaligned_reg0: got %h expected %h", d0, ed0);
    end
  endtask

  task automatic test_random();
    logic r0, p0, r1, p1, er0, ep0, er1, ep1;
    logic [31:0] d0, ed0, addr, wdata;
    logic [2:0] size;
    logic [1:0] trans;
    bit sel, wr;
    for (int n = 0; n < 300; n++) begin
      sel   = ($urandom_range(0, 9) != 0);
      trans = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3));
      wr    = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 9))
        0:       addr = Base + 32'(WinBytes) + 32'($urandom_range(0, 255));
        1:       addr = Base - 32'(1 + $urandom_range(0, 15));
        default: addr = Base + 32'($urandom_range(0, WinBytes - 1));
      endcase
      size  = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      wdata = $urandom;
      predict(sel, trans, wr, addr, size, wdata, er0, ep0, ed0, er1, ep1);
      xfer(sel, trans, wr, addr, size, wdata, r0, p0, d0, r1, p1);
      checks++;
      if (r0 !== er0 || p0 !== ep0 || r1 !== er1 || p1 !== ep1) begin
        failures++;
        $display("FAIL rand_resp #%0d addr=%h size=%0d wr=%0d: got rdy=%b%b resp=%b%b expected rdy=%b%b resp=%b%b",
                 n, addr, size, wr, r0, r1, p0, p1, er0, er1, ep0, ep1);
      end
      checks++;
      if (d0 !== ed0) begin
        failures++;
        $display("FAIL rand_rdata #%0d addr=%h size=%0d: got %h expected %h", n, addr, size, d0, ed0);
      end
    end
  endtask

  task automatic test_full_readback();
    logic r0, p0, r1, p1;
    logic [31:0] d0;
    for (int i = 0; i < NRegs; i++) begin
      xfer(1'b1, 2'd2, 1'b0, Base + 32'(4 * i), 3'd2, 32'h0, r0, p0, d0, r1, p1);
      checks++;
      if (d0 !== model[i]) begin
        failures++; $display("FAIL readback_reg%0d: got %h expected %h", i, d0, model[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    hsel = 1'b1; htrans = 2'd2; hwrite = 1'b1; haddr = Base + 32'h8; hsize = 3'd2;
    @(posedge clk); #1;
    idle_bus();
    hwdata = 32'h1234_5678;
    rst_n  = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (hreadyout !== 1'b1 || hresp !== 1'b0 || hrdata !== 32'h0) begin
      failures++;
      $display("FAIL mid_reset_outputs: got rdy=%b resp=%b data=%h expected rdy=1 resp=0 data=0",
               hreadyout, hresp, hrdata);
    end
    hwdata = 32'h0;
    rst_n  = 1'b1;
    for (int i = 0; i < NRegs; i++) model[i] = 32'h0;
  endtask

  initial begin
    test_reset();
    test_word_rw();
    test_byte_write();
    test_back_to_back();
    test_error();
    test_random();
    test_full_readback();
    test_reset_mid();
    test_full_readback();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ahb_reg_slave.md
# ahb_reg_slave

AHB-Lite slave register file for the AXI-to-AHB bridge DV environment; it sits directly downstream of `addr_decoder`. It samples the AHB address phase and feeds HADDR to an `addr_decoder` instance. In the data phase it uses the decoded word/byte offsets and the in-range flag to perform byte-lane writes and zero-wait reads on a bank of 32-bit registers. Out-of-range or illegal transfers get an error response.

## Interface
- `BaseAddr`, 32'h0000_0000: base of the register window; passed to `addr_decoder`.
- `OffsetWidth`, 6: word-offset width; register count is 2**OffsetWidth, window is 2**(OffsetWidth+2) bytes.
- `HCLK` input 1: clock.
- `HRESETn` input 1: reset. One clock; reset is synchronous and active-low.
- `HSEL` input 1: slave select.
- `HADDR` input 32: byte address.
- `HTRANS` input 2: IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- `HWRITE` input 1: 1 = write.
- `HSIZE` input 3: 0 = byte, 1 = half, 2 = word; 3..7 are illegal.
- `HWDATA` input 32: write data, valid in the data phase.
- `HREADY` input 1: bus ready, including this slave's own HREADYOUT.
- `HRDATA` output 32: read data.
- `HREADYOUT` output 1: slave ready.
- `HRESP` output 1: 0 = OKAY, 1 = ERROR.

## Operation
- Address phase is accepted when HSEL & HTRANS[1] & HREADY at the rising edge of HCLK. BUSY and IDLE are never accepted.
- On accept, register the following: valid, write, word_offset, byte_offset, HSIZE, and legal.
- legal = addr_in_range & (HSIZE<=2) & aligned.
  - half: aligned when byte_offset[0]=0.
  - word: aligned when byte_offset=0.
- States:
  - IDLE: no data phase.
  - DATA: legal data phase.
  - ERR1, ERR2: two-cycle error response.
- Transitions:
  - accept & legal → DATA.
  - accept & !legal → ERR1.
  - DATA with no new accept → IDLE.
  - DATA with a new accept → DATA or ERR1, depending on that transfer.
  - ERR1 → ERR2, unconditionally.
  - ERR2 behaves like DATA for the next accept.
- Write in DATA: at the closing edge, update the byte lanes of reg[word_offset_q] selected by the size/offset mask.
  - byte: 1<<bo.
  - half: 3<<bo.
  - word: 4'hF.
- Read in DATA: HRDATA = reg[word_offset_q], the full word, combinationally.
- Outside a read DATA phase, HRDATA = 0.
- Write data phase followed by a read of the same word: the read returns the new value. This needs no forwarding, because the write commits at the edge that opens the read data phase.
- Illegal transfers never modify any register.

## Timing
- Reset values:
  - HREADYOUT=1, HRESP=0, HRDATA=0.
  - State IDLE; all registers 0.
- Legal transfers: zero wait states. HREADYOUT=1 and HRESP=0 for the whole data phase.
- Error response:
  - ERR1: HREADYOUT=0, HRESP=1.
  - ERR2: HREADYOUT=1, HRESP=1.
- No address is accepted during ERR1, because HREADY is low.
- An address presented during ERR2 is accepted normally. The master may have driven IDLE to cancel.
- HRESETn low mid-transfer: the next edge forces IDLE and clears all registers. Any in-flight write is dropped.
- HSEL low or HTRANS IDLE while HREADY=1: the next cycle reports OKAY with HREADYOUT=1.

## Configuration
- `AHB_REG_ERROR_RESP_EN` defined: behaviour as above.
- Undefined:
  - Illegal transfers take the DATA timing (zero wait, HRESP=0).
  - Writes are still suppressed.
  - Reads return 32'h0.
  - ERR1 and ERR2 are never entered.

## Structure
- Package `ahb_reg_pkg` holds:
  - `htrans_e`, `hsize_e` and the HRESP constants.
  - The `state_e` enum (IDLE, DATA, ERR1, ERR2).
  - A function computing the 4-bit byte-lane mask from size and byte_offset.
- One sub-module: the existing `addr_decoder`, instantiated on HADDR with the same parameters.

## Test plan
- Write word 0xDEADBEEF to BaseAddr+0x04, then read it back: read returns 0xDEADBEEF, OKAY, no wait states.
- Byte write 0xAA to BaseAddr+0x06 over existing 0x11223344: readback is 0x11AA3344.
- Back-to-back write 0x5 then read of BaseAddr+0x10: read returns 0x5 in the cycle right after the write data phase.
- Read of BaseAddr+(4<<OffsetWidth):
  - HREADYOUT sequence 0,1 with HRESP 1,1.
  - No register changes.
  - Without the macro: 0x0 returned with OKAY.
- Word write to BaseAddr+0x02 (misaligned): ERROR response and reg[0] unchanged.
- Assert HRESETn low during a write data phase: the next edge shows HREADYOUT=1, HRESP=0, HRDATA=0, and all registers read back as 0.
